// File: rtl/data_memory_responder_if.sv
// MEM-stage load/store request and response bundle between the pipeline (master) and the data memory (slave).
interface data_memory_responder_if #(
    parameter int ADDR_W = 9
);
    logic              load_instr;
    logic              Read_Write;
    logic              SE_dm;
    logic [1:0]        size_dm;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              Busy;
    logic              Done;
    logic              Error;

    modport master (
        output load_instr, Read_Write, SE_dm, size_dm, Address, DataIn,
        input  DataOut, Busy, Done, Error
    );

    modport slave (
        input  load_instr, Read_Write, SE_dm, size_dm, Address, DataIn,
        output DataOut, Busy, Done, Error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Byte-serial big-endian data memory: Done pulses N+1 cycles after accept (N = 1/2/4 bytes), Busy stalls the pipeline until then.
// Optional DM_ALIGN_CHECK_EN rejects misaligned halfword/word requests in one cycle with Error.
module data_memory_responder #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input logic                    Clk,
    input logic                    R,
    data_memory_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [7:0]        mem [DEPTH];

    logic              wr_q;
    logic              se_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [31:0]       asm_q;
    logic [1:0]        cnt_q;

    logic [1:0]        last_idx;
    logic [1:0]        byte_sel;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        wr_byte;
    logic [7:0]        rd_byte;
    logic              misaligned;

    assign last_idx = (size_q == 2'b00) ? 2'd0 :
                      (size_q == 2'b01) ? 2'd1 : 2'd3;
    assign cur_addr = addr_q + ADDR_W'(cnt_q);
    // Store bytes leave most significant first, so byte k comes from lane N-1-k.
    assign byte_sel = last_idx - cnt_q;
    assign wr_byte  = din_q[{byte_sel, 3'b000} +: 8];
    assign rd_byte  = mem[cur_addr];

`ifdef DM_ALIGN_CHECK_EN
    logic err_q;

    always_comb begin
        misaligned = 1'b0;
        if (bus.size_dm == 2'b01)
            misaligned = bus.Address[0];
        else if (bus.size_dm[1])
            misaligned = (bus.Address[1:0] != 2'b00);
    end

    always_ff @(posedge Clk) begin
        if (R)
            err_q <= 1'b0;
        else if (state == IDLE && bus.load_instr)
            err_q <= misaligned;
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (R)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.load_instr)
                    state_nxt = misaligned ? DONE : ACCESS;
            end
            ACCESS: begin
                if (cnt_q == last_idx)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy    = 1'b0;
        bus.Done    = 1'b0;
        bus.Error   = 1'b0;
        bus.DataOut = '0;
        case (state)
            IDLE:   bus.Busy = bus.load_instr;
            ACCESS: bus.Busy = 1'b1;
            DONE: begin
                bus.Done = 1'b1;
`ifdef DM_ALIGN_CHECK_EN
                bus.Error = err_q;
`endif
                // A rejected load never assembles a byte, so asm_q is still zero here.
                if (!wr_q) begin
                    case (size_q)
                        2'b00:   bus.DataOut = {{24{se_q & asm_q[7]}},  asm_q[7:0]};
                        2'b01:   bus.DataOut = {{16{se_q & asm_q[15]}}, asm_q[15:0]};
                        default: bus.DataOut = asm_q;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (R) begin
            wr_q   <= 1'b0;
            se_q   <= 1'b0;
            size_q <= 2'b00;
            addr_q <= '0;
            din_q  <= '0;
            asm_q  <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_instr) begin
                        wr_q   <= bus.Read_Write;
                        se_q   <= bus.SE_dm;
                        size_q <= bus.size_dm;
                        addr_q <= bus.Address;
                        din_q  <= bus.DataIn;
                        asm_q  <= '0;
                        cnt_q  <= 2'd0;
                    end
                end
                ACCESS: begin
                    if (!wr_q)
                        asm_q <= {asm_q[23:0], rd_byte};
                    cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // The array is never reset; a reset edge only suppresses the write in flight.
    always_ff @(posedge Clk) begin
        if (!R && state == ACCESS && wr_q)
            mem[cur_addr] <= wr_byte;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: expected responses queued at issue, compared at Done.
module tb_data_memory_responder;

    typedef struct {
        logic        rw;
        logic        se;
        logic [1:0]  sz;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] data;
        logic        err;
        logic [7:0]  lat;
    } txn_t;

    logic Clk = 1'b0;
    logic R   = 1'b1;
    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];

    data_memory_responder_if #(.ADDR_W(9)) bus ();

    data_memory_responder #(.DEPTH(512), .ADDR_W(9)) dut (
        .Clk (Clk),
        .R   (R),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    function automatic txn_t mk(input logic rw, input logic se, input logic [1:0] sz,
                                input logic [8:0] a, input logic [31:0] d,
                                input logic [31:0] data, input logic err);
        txn_t t;
        t.rw = rw; t.se = se; t.sz = sz; t.addr = a; t.din = d;
        t.data = data; t.err = err;
        t.lat = err ? 8'd1 : (sz == 2'b00) ? 8'd2 : (sz == 2'b01) ? 8'd3 : 8'd5;
        return t;
    endfunction

    // Drives one request, scrambles the inputs while the access runs, and offers a
    // request during DONE (must be ignored). Returns on the cycle after DONE.
    task automatic issue(input txn_t t, output logic [31:0] o_data, output logic o_err,
                         output logic [7:0] o_lat, output logic o_busy);
        @(negedge Clk);
        bus.load_instr = 1'b1; bus.Read_Write = t.rw; bus.SE_dm = t.se;
        bus.size_dm = t.sz; bus.Address = t.addr; bus.DataIn = t.din;
        #1;
        o_busy = (bus.Busy === 1'b1);
        o_data = '0; o_err = 1'b0; o_lat = 8'd0;
        @(posedge Clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            if (bus.Done === 1'b1) begin
                o_lat = 8'(c); o_data = bus.DataOut; o_err = bus.Error;
                if (bus.Busy !== 1'b0) o_busy = 1'b0;
                bus.load_instr = 1'b1; bus.Read_Write = 1'b1;
                bus.Address = 9'($urandom); bus.DataIn = $urandom;
                break;
            end
            if (bus.Busy !== 1'b1) o_busy = 1'b0;
            bus.load_instr = 1'b0; bus.Read_Write = 1'($urandom);
            bus.SE_dm = 1'($urandom); bus.size_dm = 2'($urandom);
            bus.Address = 9'($urandom); bus.DataIn = $urandom;
        end
        @(posedge Clk);
        #1 bus.load_instr = 1'b0;
    endtask

    task automatic test_reset;
        bus.load_instr = 1'b0; bus.Read_Write = 1'b0; bus.SE_dm = 1'b0;
        bus.size_dm = 2'b00; bus.Address = '0; bus.DataIn = '0;
        R = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({bus.DataOut, bus.Done, bus.Error, bus.Busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got DataOut=%h Done=%b Error=%b Busy=%b want all 0",
                     bus.DataOut, bus.Done, bus.Error, bus.Busy);
        end
        bus.load_instr = 1'b1;
        #1;
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_follow got %b want 1", bus.Busy);
        end
        bus.load_instr = 1'b0;
        @(posedge Clk);
        #1 R = 1'b0;
    endtask

    task automatic test_word;
        txn_t t[2];
        txn_t e;
        logic [31:0] od; logic oe; logic [7:0] ol; logic ob;
        t[0] = mk(1'b1, 1'b0, 2'b10, 9'd8, 32'hDEADBEEF, 32'h0, 1'b0);
        t[1] = mk(1'b0, 1'b0, 2'b10, 9'd8, 32'h0, 32'hDEADBEEF, 1'b0);
        foreach (t[i]) begin
            exp_q.push_back(t[i]);
            issue(t[i], od, oe, ol, ob);
            e = exp_q.pop_front();
            checks++;
            if (od !== e.data) begin
                errors++; $display("FAIL word_data[%0d] got %h want %h", i, od, e.data);
            end
            checks++;
            if ({ol, oe, ob} !== {e.lat, e.err, 1'b1}) begin
                errors++;
                $display("FAIL word_ctl[%0d] got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1",
                         i, ol, oe, ob, e.lat, e.err);
            end
        end
    endtask

    task automatic test_byte_half;
        txn_t t[6];
        txn_t e;
        logic [31:0] od; logic oe; logic [7:0] ol; logic ob;
        t[0] = mk(1'b0, 1'b1, 2'b00, 9'd8,  32'h0, 32'hFFFFFFDE, 1'b0);
        t[1] = mk(1'b0, 1'b0, 2'b00, 9'd11, 32'h0, 32'h000000EF, 1'b0);
        t[2] = mk(1'b0, 1'b0, 2'b01, 9'd10, 32'h0, 32'h0000BEEF, 1'b0);
        t[3] = mk(1'b0, 1'b1, 2'b01, 9'd10, 32'h0, 32'hFFFFBEEF, 1'b0);
        t[4] = mk(1'b0, 1'b0, 2'b01, 9'd8,  32'h0, 32'h0000DEAD, 1'b0);
        t[5] = mk(1'b0, 1'b1, 2'b00, 9'd9,  32'h0, 32'hFFFFFFAD, 1'b0);
        foreach (t[i]) begin
            exp_q.push_back(t[i]);
            issue(t[i], od, oe, ol, ob);
            e = exp_q.pop_front();
            checks++;
            if (od !== e.data) begin
                errors++; $display("FAIL subword_data[%0d] got %h want %h", i, od, e.data);
            end
            checks++;
            if ({ol, oe, ob} !== {e.lat, e.err, 1'b1}) begin
                errors++;
                $display("FAIL subword_ctl[%0d] got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1",
                         i, ol, oe, ob, e.lat, e.err);
            end
        end
    endtask

`ifndef DM_ALIGN_CHECK_EN
    task automatic test_wrap;
        txn_t t[5];
        txn_t e;
        logic [31:0] od; logic oe; logic [7:0] ol; logic ob;
        t[0] = mk(1'b1, 1'b0, 2'b10, 9'd510, 32'h11223344, 32'h0, 1'b0);
        t[1] = mk(1'b0, 1'b0, 2'b00, 9'd510, 32'h0, 32'h00000011, 1'b0);
        t[2] = mk(1'b0, 1'b0, 2'b00, 9'd511, 32'h0, 32'h00000022, 1'b0);
        t[3] = mk(1'b0, 1'b0, 2'b00, 9'd0,   32'h0, 32'h00000033, 1'b0);
        t[4] = mk(1'b0, 1'b0, 2'b00, 9'd1,   32'h0, 32'h00000044, 1'b0);
        foreach (t[i]) begin
            exp_q.push_back(t[i]);
            issue(t[i], od, oe, ol, ob);
            e = exp_q.pop_front();
            checks++;
            if (od !== e.data) begin
                errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, od, e.data);
            end
            checks++;
            if ({ol, oe, ob} !== {e.lat, e.err, 1'b1}) begin
                errors++;
                $display("FAIL wrap_ctl[%0d] got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1",
                         i, ol, oe, ob, e.lat, e.err);
            end
        end
    endtask
`else
    task automatic test_align;
        txn_t t[9];
        txn_t e;
        logic [31:0] od; logic oe; logic [7:0] ol; logic ob;
        t[0] = mk(1'b1, 1'b0, 2'b00, 9'd6, 32'h000000A1, 32'h0, 1'b0);
        t[1] = mk(1'b1, 1'b0, 2'b00, 9'd7, 32'h000000A2, 32'h0, 1'b0);
        t[2] = mk(1'b1, 1'b0, 2'b00, 9'd8, 32'h000000A3, 32'h0, 1'b0);
        t[3] = mk(1'b1, 1'b0, 2'b00, 9'd9, 32'h000000A4, 32'h0, 1'b0);
        t[4] = mk(1'b1, 1'b0, 2'b10, 9'd6, 32'h55667788, 32'h0, 1'b1);
        t[5] = mk(1'b0, 1'b1, 2'b01, 9'd3, 32'h0, 32'h0, 1'b1);
        t[6] = mk(1'b0, 1'b0, 2'b01, 9'd6, 32'h0, 32'h0000A1A2, 1'b0);
        t[7] = mk(1'b0, 1'b0, 2'b01, 9'd8, 32'h0, 32'h0000A3A4, 1'b0);
        t[8] = mk(1'b0, 1'b0, 2'b11, 9'd9, 32'h0, 32'h0, 1'b1);
        foreach (t[i]) begin
            exp_q.push_back(t[i]);
            issue(t[i], od, oe, ol, ob);
            e = exp_q.pop_front();
            checks++;
            if (od !== e.data) begin
                errors++; $display("FAIL align_data[%0d] got %h want %h", i, od, e.data);
            end
            checks++;
            if ({ol, oe, ob} !== {e.lat, e.err, 1'b1}) begin
                errors++;
                $display("FAIL align_ctl[%0d] got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1",
                         i, ol, oe, ob, e.lat, e.err);
            end
        end
    endtask
`endif

    task automatic test_back_to_back;
        txn_t t[6];
        txn_t e;
        logic [31:0] od; logic oe; logic [7:0] ol; logic ob;
        t[0] = mk(1'b1, 1'b0, 2'b01, 9'd30, 32'hFFFF1234, 32'h0, 1'b0);
        t[1] = mk(1'b0, 1'b1, 2'b01, 9'd30, 32'h0, 32'h00001234, 1'b0);
        t[2] = mk(1'b0, 1'b1, 2'b00, 9'd31, 32'h0, 32'h00000034, 1'b0);
        t[3] = mk(1'b1, 1'b1, 2'b00, 9'd31, 32'h12345680, 32'h0, 1'b0);
        t[4] = mk(1'b0, 1'b1, 2'b01, 9'd30, 32'h0, 32'h00001280, 1'b0);
        t[5] = mk(1'b0, 1'b1, 2'b00, 9'd31, 32'h0, 32'hFFFFFF80, 1'b0);
        foreach (t[i]) begin
            exp_q.push_back(t[i]);
            issue(t[i], od, oe, ol, ob);
            e = exp_q.pop_front();
            checks++;
            if (od !== e.data) begin
                errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, od, e.data);
            end
            checks++;
            if ({ol, oe, ob} !== {e.lat, e.err, 1'b1}) begin
                errors++;
                $display("FAIL b2b_ctl[%0d] got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1",
                         i, ol, oe, ob, e.lat, e.err);
            end
        end
    endtask

    task automatic test_reset_mid;
        txn_t e;
        txn_t t;
        logic [31:0] od; logic oe; logic [7:0] ol; logic ob;
        logic done_seen;
        t = mk(1'b1, 1'b0, 2'b10, 9'd20, 32'h0, 32'h0, 1'b0);
        exp_q.push_back(t);
        issue(t, od, oe, ol, ob);
        e = exp_q.pop_front();
        checks++;
        if (ol !== e.lat) begin
            errors++; $display("FAIL rstmid_preload lat got %0d want %0d", ol, e.lat);
        end
        @(negedge Clk);
        bus.load_instr = 1'b1; bus.Read_Write = 1'b1; bus.SE_dm = 1'b0;
        bus.size_dm = 2'b10; bus.Address = 9'd20; bus.DataIn = 32'hAABBCCDD;
        @(posedge Clk);
        #1 bus.load_instr = 1'b0;
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if (bus.Done === 1'b1) done_seen = 1'b1;
            @(posedge Clk);
        end
        #1 R = 1'b1;
        @(negedge Clk);
        if (bus.Done === 1'b1) done_seen = 1'b1;
        @(posedge Clk);
        #1 R = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle_busy got %b want 0", bus.Busy);
        end
        repeat (5) begin
            if (bus.Done === 1'b1) done_seen = 1'b1;
            @(negedge Clk);
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_done got %b want 0", done_seen);
        end
        t = mk(1'b0, 1'b0, 2'b10, 9'd20, 32'h0, 32'hAABB0000, 1'b0);
        exp_q.push_back(t);
        issue(t, od, oe, ol, ob);
        e = exp_q.pop_front();
        checks++;
        if (od !== e.data) begin
            errors++; $display("FAIL rstmid_data got %h want %h", od, e.data);
        end
        checks++;
        if ({ol, oe, ob} !== {e.lat, e.err, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_ctl got lat=%0d err=%b busy_ok=%b want lat=%0d err=%b busy_ok=1",
                     ol, oe, ob, e.lat, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
`ifndef DM_ALIGN_CHECK_EN
        test_wrap();
`else
        test_align();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

- Byte-addressed data memory that answers the MEM-stage load/store requests produced by the pipeline's control path: `load_instr`, `Read_Write`, `SE_dm`, `size_dm`.
- Storage is a single byte-wide array, so each access is serialised: one byte per cycle, big-endian, the same byte order the instruction memory uses.
- Busy stalls the pipeline until the access completes.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.

## Interface
Parameters:
- DEPTH, 512, number of bytes in the memory array.
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W.

Ports:
- Clk  input  1  clock. One clock; all state updates on the rising edge.
- R  input  1  reset; synchronous, active-high.
- load_instr  input  1  request valid; memory access requested this cycle.
- Read_Write  input  1  0 = load, 1 = store.
- SE_dm  input  1  load sign-extension select; 1 = sign-extend, 0 = zero-extend. Ignored for word loads and for stores.
- size_dm  input  2  access size: 00 = byte, 01 = halfword, 10 or 11 = word.
- Address  input  ADDR_W  byte address of the first (most significant) byte.
- DataIn  input  32  store data, right-justified.
- DataOut  output  32  load result; valid only while Done = 1.
- Busy  output  1  stall request to the pipeline.
- Done  output  1  one-cycle completion pulse.
- Error  output  1  misaligned access flag; valid while Done = 1.

## Operation
- Byte count N is derived from size_dm: byte = 1, halfword = 2, word = 4.
- FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - Busy = load_instr (combinational).
  - If load_instr = 1, capture Read_Write, SE_dm, size_dm, Address and DataIn into internal registers.
  - Set byte counter = 0 and go to ACCESS.
- **ACCESS**
  - Busy = 1.
  - Each cycle transfers byte k = counter at address (Addr + k) mod DEPTH.
  - Store, size N: write byte k = DataIn bits [8(N-k)-1 : 8(N-k-1)]. Examples: word at A writes Mem[A] = DataIn[31:24]; halfword at A writes Mem[A] = DataIn[15:8] and Mem[A+1] = DataIn[7:0].
  - Load: shift the byte into an assembly register, most significant byte first.
  - When counter = N-1, go to DONE; otherwise counter += 1.
- **DONE**
  - Busy = 0, Done = 1.
  - DataOut holds the assembled value, extended to 32 bits:
    - byte: bit 7 replicated if SE_dm = 1, else zero-filled;
    - halfword: bit 15 replicated if SE_dm = 1, else zero-filled;
    - word: unmodified.
  - For stores DataOut = 0.
  - Unconditionally go to IDLE. A load_instr seen while in DONE is not accepted; it belongs to the instruction the pipeline has just released, and a new request is accepted in the following IDLE cycle.
- Address wrap-around: all byte addresses are taken modulo DEPTH. A word at DEPTH-2 touches bytes DEPTH-2, DEPTH-1, 0, 1.
- Inputs are sampled only in the IDLE accept cycle. Changes during ACCESS are ignored.

## Timing
- Reset values: state = IDLE, DataOut = 0, Done = 0, Error = 0, Busy = 0 (Busy also follows load_instr in IDLE).
- Reset does not clear the memory array.
- Reset during ACCESS: the FSM returns to IDLE on that edge. Store bytes already written stay written; the remaining bytes are not written. No Done pulse is issued.
- Latency: request accepted at edge 0, Done asserted in cycle N+1.
  - byte: Done in cycle 2;
  - halfword: Done in cycle 3;
  - word: Done in cycle 5.
- Busy is high from the request cycle through the last ACCESS cycle inclusive, and low in the DONE cycle, so the pipeline advances at the edge ending DONE.
- Throughput: at most one access per N+2 cycles.
- Store bytes become visible to later accesses on the edge that ends the byte's ACCESS cycle.

## Configuration
- Macro: DM_ALIGN_CHECK_EN.
- **Defined:** the alignment check runs in the IDLE accept cycle.
  - Halfword requires Address[0] = 0.
  - Word requires Address[1:0] = 00.
  - A misaligned request skips ACCESS and goes directly to DONE with Error = 1 and DataOut = 0. No byte is written.
  - Latency for a misaligned request is 1 cycle; Busy is high in the request cycle only.
- **Not defined:** Error is constant 0. Misaligned requests proceed byte-serially with normal wrap-around.

## Test plan
- Store word 0xDEADBEEF at 8, then load word at 8:
  - each access has Done in cycle 5;
  - the load returns DataOut = 0xDEADBEEF;
  - Busy is high in cycles 0-4.
- After the above store:
  - signed byte load at 8 -> 0xFFFFFFDE;
  - unsigned byte load at 11 -> 0x000000EF.
- After the above store:
  - unsigned halfword load at 10 -> 0x0000BEEF;
  - signed halfword load at 10 -> 0xFFFFBEEF;
  - Done in cycle 3 for both.
- Without DM_ALIGN_CHECK_EN: store word 0x11223344 at 510, then load bytes at 510, 511, 0 and 1 -> 0x11, 0x22, 0x33, 0x44.
- With DM_ALIGN_CHECK_EN:
  - store word at 6 -> Done and Error in cycle 1, and memory at 6-9 unchanged;
  - load halfword at 3 -> Error = 1, DataOut = 0.
- Reset mid-operation:
  - Preload word 0 at 20.
  - Store word 0xAABBCCDD at 20, asserting R in the third ACCESS cycle.
  - Required response: the FSM returns to IDLE, no Done pulse occurs, and a subsequent word load at 20 returns 0xAABB0000.
